// File: rtl/hwpe_stream_downsizer_if.sv
// rtl/hwpe_stream_downsizer_if.sv - valid/ready stream interface with byte strobes
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_downsizer.sv
// rtl/hwpe_stream_downsizer.sv - splits each wide stream word into RATIO narrow beats, LSB slice first
module hwpe_stream_downsizer #(
    parameter int unsigned DATA_WIDTH_IN = 32,
    parameter int unsigned RATIO         = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    output logic                       busy,
    output logic [$clog2(RATIO)-1:0]   beat_idx,
    hwpe_stream_intf_stream.sink       push,
    hwpe_stream_intf_stream.source     pop
);
    localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN / RATIO;
    localparam int unsigned STRB_IN        = DATA_WIDTH_IN / 8;
    localparam int unsigned STRB_OUT       = DATA_WIDTH_OUT / 8;
    localparam int unsigned CNT_W          = $clog2(RATIO);

    typedef enum logic {EMPTY, SERIALIZE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH_IN-1:0] data_q, data_d;
    logic [STRB_IN-1:0] strb_q, strb_d;

    logic full;
    logic last_beat;
    logic push_hs;
    logic pop_hs;

    // Slice views let cnt_q select a beat without multiply/offset arithmetic.
    logic [RATIO-1:0][DATA_WIDTH_OUT-1:0] data_slices;
    logic [RATIO-1:0][STRB_OUT-1:0]       strb_slices;

    assign full        = (state_q == SERIALIZE);
    assign last_beat   = (cnt_q == CNT_W'(RATIO - 1));
    assign data_slices = data_q;
    assign strb_slices = strb_q;

    assign push.ready = rst_n & ~clear & (~full | (pop.ready & last_beat));
    assign pop.valid  = full;
    assign pop.data   = data_slices[cnt_q];
    assign pop.strb   = strb_slices[cnt_q];
    assign busy       = full;
    assign beat_idx   = cnt_q;

    assign push_hs = push.valid & push.ready;
    assign pop_hs  = pop.valid & pop.ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        strb_d  = strb_q;
        case (state_q)
            EMPTY: begin
                if (push_hs) begin
                    state_d = SERIALIZE;
                    cnt_d   = '0;
                    data_d  = push.data;
                    strb_d  = push.strb;
                end
            end
            SERIALIZE: begin
                if (pop_hs) begin
                    if (!last_beat) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (push_hs) begin
                        cnt_d  = '0;
                        data_d = push.data;
                        strb_d = push.strb;
                    end else begin
                        state_d = EMPTY;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any handshake in the same cycle.
        if (clear) begin
            state_d = EMPTY;
            cnt_d   = '0;
            data_d  = '0;
            strb_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_downsizer.sv
// tb/tb_hwpe_stream_downsizer.sv - randomized and directed bench with a beat-queue reference model
module tb_hwpe_stream_downsizer;
    localparam int DW = 32;
    localparam int R  = 4;
    localparam int DO = DW / R;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic busy;
    logic [$clog2(R)-1:0] beat_idx;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DO)) pop_if ();

    hwpe_stream_downsizer #(.DATA_WIDTH_IN(DW), .RATIO(R)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .busy     (busy),
        .beat_idx (beat_idx),
        .push     (push_if),
        .pop      (pop_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DO-1:0]   d;
        logic [DO/8-1:0] s;
        int              idx;
    } beat_t;

    typedef struct {
        logic [DO-1:0]   d;
        logic [DO/8-1:0] s;
        int              cyc;
    } obs_t;

    beat_t exp_q[$];
    obs_t  obs[$];
    logic  zeroed = 1'b1;
    int    cycle = 0;
    int    total = 0;
    int    bad = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // Model: a word becomes R queued beats; outputs follow the queue head.
    always @(negedge clk) begin
        int   sz;
        logic er;
        sz = exp_q.size();
        er = rst_n && !clear && (sz == 0 || (sz == 1 && pop_if.ready));
        chk("push_ready", {31'd0, push_if.ready}, {31'd0, er});
        chk("pop_valid", {31'd0, pop_if.valid}, {31'd0, sz != 0});
        chk("busy", {31'd0, busy}, {31'd0, sz != 0});
        if (sz != 0) begin
            chk("pop_data", 32'(pop_if.data), 32'(exp_q[0].d));
            chk("pop_strb", 32'(pop_if.strb), 32'(exp_q[0].s));
            chk("beat_idx", 32'(beat_idx), 32'(exp_q[0].idx));
        end else begin
            chk("beat_idx_idle", 32'(beat_idx), 32'd0);
            if (zeroed) begin
                chk("pop_data_zero", 32'(pop_if.data), 32'd0);
                chk("pop_strb_zero", 32'(pop_if.strb), 32'd0);
            end
        end
        if (pop_if.valid && pop_if.ready && rst_n && !clear)
            obs.push_back('{d: pop_if.data, s: pop_if.strb, cyc: cycle});
        if (!rst_n || clear) begin
            exp_q.delete();
            zeroed = 1'b1;
        end else begin
            if (sz != 0 && pop_if.ready) void'(exp_q.pop_front());
            if (push_if.valid && er) begin
                for (int i = 0; i < R; i++)
                    exp_q.push_back('{d: push_if.data[i*DO +: DO], s: push_if.strb[i*(DO/8) +: DO/8], idx: i});
                zeroed = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic [DW/8-1:0] s, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        push_if.valid = 1'b1;
        push_if.data  = d;
        push_if.strb  = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (push_if.ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
        acc = cycle;
        push_if.valid = 1'b0;
    endtask

    logic [7:0] lit_dbef[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] lit_part[4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic       lit_pstr[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int acc;
        rst_n = 1'b0;
        clear = 1'b0;
        push_if.valid = 1'b1;
        push_if.data  = 32'h12345678;
        push_if.strb  = 4'hF;
        pop_if.ready  = 1'b1;
        repeat (2) cyc();
        chk("rst_pop_valid", {31'd0, pop_if.valid}, 32'd0);
        chk("rst_push_ready", {31'd0, push_if.ready}, 32'd0);
        push_if.valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_push_ready", {31'd0, push_if.ready}, 32'd1);

        obs.delete();
        push_word(32'hDEADBEEF, 4'hF, acc);
        repeat (6) cyc();
        chk("single_cnt", obs.size(), 32'd4);
        if (obs.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("single_data", 32'(obs[i].d), 32'(lit_dbef[i]));
                chk("single_strb", 32'(obs[i].s), 32'd1);
                chk("single_cyc", obs[i].cyc, acc + i);
            end
        end
        chk("single_busy", {31'd0, busy}, 32'd0);

        obs.delete();
        push_word(32'h03020100, 4'hF, acc);
        push_word(32'h07060504, 4'hF, acc);
        repeat (8) cyc();
        chk("b2b_cnt", obs.size(), 32'd8);
        if (obs.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("b2b_data", 32'(obs[i].d), i);
                chk("b2b_cyc", obs[i].cyc, obs[0].cyc + i);
            end
        end

        obs.delete();
        push_word(32'hDEADBEEF, 4'hF, acc);
        repeat (2) cyc();
        pop_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("bp_data", 32'(pop_if.data), 32'hAD);
            chk("bp_idx", 32'(beat_idx), 32'd2);
            chk("bp_push_ready", {31'd0, push_if.ready}, 32'd0);
            cyc();
        end
        pop_if.ready = 1'b1;
        repeat (4) cyc();
        chk("bp_cnt", obs.size(), 32'd4);
        if (obs.size() == 4) chk("bp_resume", 32'(obs[3].d), 32'hDE);

        obs.delete();
        push_word(32'h11223344, 4'b0101, acc);
        repeat (6) cyc();
        chk("part_cnt", obs.size(), 32'd4);
        if (obs.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("part_data", 32'(obs[i].d), 32'(lit_part[i]));
                chk("part_strb", 32'(obs[i].s), {31'd0, lit_pstr[i]});
            end
        end

        obs.delete();
        push_word(32'hDEADBEEF, 4'hF, acc);
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        #1;
        chk("clr_valid", {31'd0, pop_if.valid}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_idx", 32'(beat_idx), 32'd0);
        obs.delete();
        push_word(32'hCAFEF00D, 4'hF, acc);
        repeat (6) cyc();
        chk("clr_next_cnt", obs.size(), 32'd4);
        if (obs.size() > 0) chk("clr_next_first", 32'(obs[0].d), 32'h0D);

        for (int n = 0; n < 3000; n++) begin
            push_if.valid = ($urandom_range(0, 99) < 60);
            push_if.data  = $urandom;
            push_if.strb  = 4'($urandom);
            pop_if.ready  = ($urandom_range(0, 99) < 70);
            clear         = ($urandom_range(0, 99) < 2);
            rst_n         = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst_n = 1'b1;
        clear = 1'b0;
        push_if.valid = 1'b0;
        pop_if.ready  = 1'b1;
        repeat (8) cyc();
        chk("drain_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
